// File: rtl/ldpc_dec_sched.sv
`default_nettype none
// ============================================================================
// ldpc_dec_sched: round-robin scheduler sharing one LDPC decoder between two
// requesters, with completion watchdog and decoder recovery. Revision: 1.0
// ============================================================================
module ldpc_dec_sched #(
  parameter int TIMEOUT     = 40,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [11:0]      req_code0,
  input  logic [11:0]      req_code1,
  output logic [1:0]       req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [3:0]       resp_msg,
  output logic             resp_err,
  output logic [11:0]      dec_code,
  output logic             dec_start,
  output logic             dec_rst_n,
  input  logic [3:0]       dec_msg,
  input  logic             dec_tx_en,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [11:0]      dec_code_q, dec_code_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [RC_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic             resp_id_q, resp_id_d;
  logic [3:0]       resp_msg_q, resp_msg_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             winner;
  logic [1:0]       grant_oh;

  // Contention goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    winner   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    grant_oh = 2'b00;
    if (state_q == S_IDLE && (|req_valid)) begin
      grant_oh[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    dec_code_d   = dec_code_q;
    wd_cnt_d     = wd_cnt_q;
    rec_cnt_d    = rec_cnt_q;
    resp_id_d    = resp_id_q;
    resp_msg_d   = resp_msg_q;
    resp_err_d   = resp_err_q;
    done_cnt_d   = done_cnt_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|grant_oh) begin
          dec_code_d   = winner ? req_code1 : req_code0;
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (dec_tx_en) begin
          resp_msg_d = dec_msg;
          resp_err_d = 1'b0;
          resp_id_d  = grant_id_q;
          if (done_cnt_q != {CNT_W{1'b1}}) done_cnt_d = done_cnt_q + 1'b1;
          state_d    = S_RESP;
        end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          resp_msg_d = 4'h0;
          resp_err_d = 1'b1;
          resp_id_d  = grant_id_q;
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
          rec_cnt_d  = '0;
          state_d    = S_RECOVER;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (rec_cnt_q == RC_W'(RECOVER_CYC - 1)) begin
          state_d = S_RESP;
        end else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      dec_code_q   <= '0;
      wd_cnt_q     <= '0;
      rec_cnt_q    <= '0;
      resp_id_q    <= 1'b0;
      resp_msg_q   <= '0;
      resp_err_q   <= 1'b0;
      done_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      dec_code_q   <= dec_code_d;
      wd_cnt_q     <= wd_cnt_d;
      rec_cnt_q    <= rec_cnt_d;
      resp_id_q    <= resp_id_d;
      resp_msg_q   <= resp_msg_d;
      resp_err_q   <= resp_err_d;
      done_cnt_q   <= done_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req_ready  = grant_oh;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_msg   = resp_msg_q;
  assign resp_err   = resp_err_q;
  assign dec_code   = dec_code_q;
  assign dec_start  = (state_q == S_LAUNCH);
  assign dec_rst_n  = !(rst || state_q == S_RECOVER);
  assign busy       = (state_q != S_IDLE);
  assign done_cnt   = done_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_dec_sched.sv
`default_nettype none
// ============================================================================
// tb_ldpc_dec_sched: directed scoreboard bench with a behavioural decoder
// model (msg = code[3:0] ^ 4'h5, programmable latency). Revision: 1.0
// ============================================================================
module tb_ldpc_dec_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [11:0] req_code0, req_code1;
  logic [1:0]  req_ready;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [3:0]  resp_msg;
  logic [11:0] dec_code;
  logic        dec_start, dec_rst_n, dec_tx_en, busy;
  logic [3:0]  dec_msg;
  logic [15:0] done_cnt, err_cnt;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  int   model_lat = 28;
  int   dec_cnt   = 0;
  logic model_tx  = 1'b0;
  logic spur_tx   = 1'b0;

  ldpc_dec_sched #(.TIMEOUT(40), .RECOVER_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code0(req_code0),
    .req_code1(req_code1), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_msg(resp_msg),
    .resp_err(resp_err), .dec_code(dec_code), .dec_start(dec_start),
    .dec_rst_n(dec_rst_n), .dec_msg(dec_msg), .dec_tx_en(dec_tx_en),
    .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign dec_tx_en = model_tx | spur_tx;
  assign dec_msg   = dec_code[3:0] ^ 4'h5;

  // Decoder model: tx_en pulses model_lat cycles after the start cycle; 0 = never.
  initial begin
    forever begin
      @(negedge clk);
      model_tx = 1'b0;
      if (dec_cnt > 0) begin
        dec_cnt--;
        if (dec_cnt == 0) model_tx = 1'b1;
      end
      if (dec_start) dec_cnt = model_lat;
      if (!dec_rst_n) dec_cnt = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {26'd0, resp_id, resp_msg, resp_err}, 32'hFFFF_FFFF);
        end else begin
          check("resp_id_msg_err", {26'd0, resp_id, resp_msg, resp_err}, {26'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

  task automatic send(input int id, input logic [11:0] code);
    int k;
    @(posedge clk); #1;
    if (id == 0) req_code0 = code; else req_code1 = code;
    req_valid[id] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[id] && k < 100);
    if (!req_ready[id]) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || resp_valid) && k < budget);
    if (busy || resp_valid) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int   k, g, first_low, lows, resp_k;
    bit   both_ready, code_bad, hold_bad, rdy_bad, start_bad, spur_bad;
    logic [11:0] cur_code;
    logic [5:0]  snap;

    rst = 1'b1; req_valid = 2'b00; req_code0 = '0; req_code1 = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dec_rst_n", {31'd0, dec_rst_n}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctl", {req_ready, resp_valid, resp_id, resp_msg, resp_err, dec_start, busy}, 0);
    check("reset_code", {20'd0, dec_code}, 0);
    check("reset_cnt", {done_cnt, err_cnt}, 0);
    check("reset_dec_rst_n", {31'd0, dec_rst_n}, 1);

    // Single request: A5C -> msg 9, start one cycle after accept, resp 29 after start.
    exp_q.push_back({1'b0, 4'h9, 1'b0});
    send(0, 12'hA5C);
    @(negedge clk);
    check("t1_start", {31'd0, dec_start}, 1);
    check("t1_code", {20'd0, dec_code}, 32'hA5C);
    k = 0;
    while (!resp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", k, 29);
    wait_idle(100);
    check("t1_done_cnt", {16'd0, done_cnt}, 1);

    // Both requesters held valid after reset: grant order 0,1,0.
    do_reset();
    exp_q.push_back({1'b0, 4'h4, 1'b0});
    exp_q.push_back({1'b1, 4'h7, 1'b0});
    exp_q.push_back({1'b0, 4'h4, 1'b0});
    @(posedge clk); #1;
    req_code0 = 12'h111; req_code1 = 12'h222; req_valid = 2'b11;
    g = 0; both_ready = 0; code_bad = 0; cur_code = '0;
    for (int c = 0; c < 200 && g < 3; c++) begin
      @(negedge clk);
      if (req_ready == 2'b11) both_ready = 1;
      if (busy && g > 0 && dec_code !== cur_code) code_bad = 1;
      if (|(req_ready & req_valid)) begin
        check($sformatf("t2_grant%0d", g), {30'd0, req_ready}, (g == 1) ? 2 : 1);
        cur_code = (g == 1) ? 12'h222 : 12'h111;
        g++;
        if (g == 3) begin
          @(posedge clk); #1 req_valid = 2'b00;
        end
      end
    end
    check("t2_grants", g, 3);
    check("t2_both_ready", {31'd0, both_ready}, 0);
    check("t2_code_stable", {31'd0, code_bad}, 0);
    wait_idle(100);
    check("t2_done_cnt", {16'd0, done_cnt}, 3);

    // Watchdog: decoder silent -> 40 WAIT cycles, 2 recovery cycles, error response.
    model_lat = 0;
    exp_q.push_back({1'b0, 4'h0, 1'b1});
    send(0, 12'h5A3);
    @(negedge clk);
    check("t3_start", {31'd0, dec_start}, 1);
    first_low = -1; lows = 0; resp_k = -1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (!dec_rst_n) begin
        if (first_low < 0) first_low = j;
        lows++;
      end
      if (resp_valid) begin
        resp_k = j;
        break;
      end
    end
    check("t3_first_low", first_low, 41);
    check("t3_low_cycles", lows, 2);
    check("t3_resp_cycle", resp_k, 43);
    wait_idle(100);
    check("t3_err_cnt", {16'd0, err_cnt}, 1);
    model_lat = 28;
    exp_q.push_back({1'b1, 4'h3, 1'b0});
    send(1, 12'h3C6);
    wait_idle(100);
    check("t3_done_cnt", {16'd0, done_cnt}, 4);

    // Back-pressure: response held 10 cycles with requester 1 waiting.
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 4'h5, 1'b0});
    send(0, 12'h0F0);
    k = 0;
    while (!resp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    snap = {resp_id, resp_msg, resp_err};
    check("t4_resp_seen", {31'd0, resp_valid}, 1);
    @(posedge clk); #1 req_code1 = 12'h3C6; req_valid = 2'b10;
    hold_bad = 0; rdy_bad = 0; start_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!resp_valid || {resp_id, resp_msg, resp_err} !== snap) hold_bad = 1;
      if (req_ready != 2'b00) rdy_bad = 1;
      if (dec_start) start_bad = 1;
    end
    check("t4_hold_stable", {31'd0, hold_bad}, 0);
    check("t4_ready_low", {31'd0, rdy_bad}, 0);
    check("t4_no_start", {31'd0, start_bad}, 0);
    @(posedge clk); #1 resp_ready = 1'b1; req_valid = 2'b00;
    wait_idle(100);
    check("t4_done_cnt", {16'd0, done_cnt}, 5);

    // Reset during WAIT cycle 15: no response, requester 0 wins afterwards.
    send(0, 12'h123);
    @(negedge clk);
    repeat (14) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_dec_rst_n", {31'd0, dec_rst_n}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_reset_ctl", {req_ready, resp_valid, resp_id, resp_msg, resp_err, dec_start, busy}, 0);
    check("t5_reset_code", {20'd0, dec_code}, 0);
    check("t5_reset_cnt", {done_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    req_code0 = 12'h5A7; req_code1 = 12'h999; req_valid = 2'b11;
    exp_q.push_back({1'b0, 4'h2, 1'b0});
    @(negedge clk);
    check("t5_priority", {30'd0, req_ready}, 1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle(100);
    check("t5_done_cnt", {16'd0, done_cnt}, 1);

    // tx_en on the final watchdog cycle wins; spurious tx_en in IDLE is ignored.
    model_lat = 40;
    exp_q.push_back({1'b1, 4'hF, 1'b0});
    send(1, 12'h00A);
    wait_idle(100);
    check("t6_err_cnt", {16'd0, err_cnt}, 0);
    check("t6_done_cnt", {16'd0, done_cnt}, 2);
    spur_bad = 0;
    @(posedge clk); #1 spur_tx = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid || busy) spur_bad = 1;
    end
    @(posedge clk); #1 spur_tx = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || busy) spur_bad = 1;
    end
    check("t6_spurious", {31'd0, spur_bad}, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
